// File: rtl/mbgd_grad_update_if.sv
// Error-row stream between the producer of (h - y) rows and the gradient update block.
interface mbgd_grad_update_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 8
);
    logic              err_valid;
    logic              err_ready;
    logic [DW*N-1:0]   err_in;

    modport master (output err_valid, output err_in, input  err_ready);
    modport slave  (input  err_valid, input  err_in, output err_ready);
endinterface

// File: rtl/mbgd_grad_update.sv
// Mini-batch gradient descent weight update: sums 2^BATCH_BITS error rows per lane,
// then applies w -= (sum >>> (BATCH_BITS+LR_SHIFT)) with saturation.
module mbgd_grad_update #(
    parameter int unsigned N          = 8,
    parameter int unsigned DW         = 8,
    parameter int unsigned BATCH_BITS = 2,
    parameter int unsigned LR_SHIFT   = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 abort,
    mbgd_grad_update_if.slave    err_if,
    input  logic                 w_load,
    input  logic [DW*N-1:0]      w_in,
    output logic [DW*N-1:0]      w_out,
    output logic                 busy,
    output logic                 upd_valid
);
    localparam int unsigned AW  = DW + BATCH_BITS + 1;
    localparam int unsigned DFW = AW + 1;
    localparam int unsigned CW  = BATCH_BITS + 1;
    localparam int unsigned SH  = BATCH_BITS + LR_SHIFT;
    localparam logic [CW-1:0]         LAST    = CW'((2 ** BATCH_BITS) - 1);
    localparam logic signed [DFW-1:0] SAT_MAX = DFW'((2 ** (DW - 1)) - 1);
    localparam logic signed [DFW-1:0] SAT_MIN = DFW'(-(2 ** (DW - 1)));

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic signed [AW-1:0]   r_acc [N];
    logic [CW-1:0]          r_cnt;
    logic [DW*N-1:0]        r_w;

    logic                   w_accept;
    logic                   w_abort;
    logic                   w_clear;
    logic                   w_err_ready;
    logic signed [AW-1:0]   w_err_ext [N];
    logic signed [DFW-1:0]  w_diff [N];
    logic signed [DFW-1:0]  w_sat [N];
    logic [DW*N-1:0]        w_new;

    // abort only matters while a batch is in flight, and beats a same-edge row
    assign w_abort  = abort && ((r_state == S_ACCUM) || (r_state == S_UPDATE));
    assign w_accept = err_if.err_valid && (r_state == S_ACCUM) && !abort;
    assign w_clear  = ((r_state == S_IDLE) && start) || w_abort;

    assign err_if.err_ready = w_err_ready;
    assign w_out            = r_w;

    // State register
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_err_ready = 1'b0;
        busy        = 1'b1;
        upd_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                w_err_ready = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_accept && (r_cnt == LAST)) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_state_nxt = abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                upd_valid   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-lane gradient step: floor shift of the sum, subtract, clamp to DW bits
    always_comb begin
        w_new = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_err_ext[i] = AW'($signed(err_if.err_in[i*DW +: DW]));
            w_diff[i]    = DFW'($signed(r_w[i*DW +: DW])) - DFW'(r_acc[i] >>> SH);
            if (w_diff[i] > SAT_MAX) begin
                w_sat[i] = SAT_MAX;
            end else if (w_diff[i] < SAT_MIN) begin
                w_sat[i] = SAT_MIN;
            end else begin
                w_sat[i] = w_diff[i];
            end
            w_new[i*DW +: DW] = w_sat[i][DW-1:0];
        end
    end

    // Accumulators, row counter and weight register
    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < int'(N); i++) r_acc[i] <= '0;
            r_cnt <= '0;
            r_w   <= '0;
        end else begin
            if (w_clear) begin
                for (int i = 0; i < int'(N); i++) r_acc[i] <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                for (int i = 0; i < int'(N); i++) r_acc[i] <= r_acc[i] + w_err_ext[i];
                r_cnt <= r_cnt + CW'(1);
            end
            if ((r_state == S_IDLE) && w_load) begin
                r_w <= w_in;
            end else if ((r_state == S_UPDATE) && !abort) begin
                r_w <= w_new;
            end
        end
    end
endmodule

// File: tb/tb_mbgd_grad_update.sv
// Bench for mbgd_grad_update: expected weights queued per batch, popped on upd_valid.
module tb_mbgd_grad_update;
    localparam int unsigned N  = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned BB = 2;
    localparam int unsigned LS = 1;
    localparam int unsigned W  = N * DW;
    localparam int          DIV = 8;   // 2^(BB+LS)

    typedef logic [W-1:0] row_t;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic w_load = 1'b0;
    row_t w_in = '0;
    row_t w_out;
    logic busy;
    logic upd_valid;

    mbgd_grad_update_if #(.N(N), .DW(DW)) e_if ();

    mbgd_grad_update #(.N(N), .DW(DW), .BATCH_BITS(BB), .LR_SHIFT(LS)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort), .err_if(e_if.slave),
        .w_load(w_load), .w_in(w_in), .w_out(w_out), .busy(busy), .upd_valid(upd_valid)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = -100;
    int   n_hs = 0;
    row_t sb[$];
    row_t wm = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts handshakes, checks every upd_valid against the scoreboard
    always @(negedge clk) begin
        row_t exp_w;
        if (!resetn && e_if.err_valid && e_if.err_ready && !abort) begin
            n_hs++;
            last_acc = cyc;
        end
        if (upd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected w_out=%h (no batch expected)", w_out);
            end else begin
                exp_w = sb.pop_front();
                if (w_out !== exp_w) begin
                    errors++;
                    $display("FAIL upd_w_out got %h want %h", w_out, exp_w);
                end
            end
            checks++;
            if (cyc - last_acc != 2) begin
                errors++;
                $display("FAIL upd_latency got %0d want 2", cyc - last_acc);
            end
        end
    end

    function automatic row_t exp_update(input row_t w, input row_t rows[$]);
        row_t r;
        row_t res;
        logic signed [DW-1:0] lv;
        int s, g, nw;
        res = '0;
        for (int l = 0; l < int'(N); l++) begin
            s = 0;
            foreach (rows[k]) begin
                r  = rows[k];
                lv = r[l*DW +: DW];
                s += int'(lv);
            end
            if (s >= 0) g = s / DIV;
            else        g = -((-s + DIV - 1) / DIV);
            lv = w[l*DW +: DW];
            nw = int'(lv) - g;
            if (nw > 127)  nw = 127;
            if (nw < -128) nw = -128;
            res[l*DW +: DW] = DW'(nw);
        end
        return res;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int l = 0; l < int'(N); l++) r[l*DW +: DW] = DW'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic load_w(input row_t v);
        w_load = 1'b1;
        w_in   = v;
        @(posedge clk); #1;
        w_load = 1'b0;
        wm     = v;
    endtask

    task automatic start_batch();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_rows(input row_t rows[$], input int gap_pct, output bit ok);
        bit done;
        int guard;
        ok = 1'b1;
        foreach (rows[k]) begin
            done  = 1'b0;
            guard = 0;
            while (!done) begin
                e_if.err_valid = ($urandom_range(0, 99) >= gap_pct);
                e_if.err_in    = rows[k];
                @(negedge clk);
                done = e_if.err_valid && e_if.err_ready;
                @(posedge clk); #1;
                guard++;
                if (guard > 60) begin
                    ok   = 1'b0;
                    done = 1'b1;
                end
            end
        end
        e_if.err_valid = 1'b0;
    endtask

    task automatic wait_upd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic queue_batch(input row_t rows[$]);
        row_t e;
        e = exp_update(wm, rows);
        sb.push_back(e);
        wm = e;
    endtask

    task automatic test_reset();
        resetn = 1'b1; start = 1'b1; w_load = 1'b1; w_in = '1;
        e_if.err_valid = 1'b1; e_if.err_in = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (w_out !== '0)        begin errors++; $display("FAIL reset_w_out got %h want 0", w_out); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (e_if.err_ready !== 1'b0) begin errors++; $display("FAIL reset_err_ready got %b want 0", e_if.err_ready); end
        checks++; if (upd_valid !== 1'b0)  begin errors++; $display("FAIL reset_upd_valid got %b want 0", upd_valid); end
        start = 1'b0; w_load = 1'b0; e_if.err_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        wm = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        row_t q[$];
        bit ok;
        load_w({N{8'h10}});
        repeat (4) q.push_back({N{8'h08}});
        queue_batch(q);
        start_batch();
        checks++; if (busy !== 1'b1 || e_if.err_ready !== 1'b1) begin
            errors++; $display("FAIL basic_accum busy=%b err_ready=%b want 1 1", busy, e_if.err_ready);
        end
        drive_rows(q, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_rows_timeout got 0 want 1"); end
        wait_upd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_upd_timeout got 0 want 1"); end
        checks++; if (w_out !== {N{8'h0C}}) begin errors++; $display("FAIL basic_w_out got %h want %h", w_out, {N{8'h0C}}); end
        checks++; if (busy !== 1'b0 || upd_valid !== 1'b0) begin
            errors++; $display("FAIL basic_idle busy=%b upd_valid=%b want 0 0", busy, upd_valid);
        end
    endtask

    task automatic test_signed();
        row_t q[$];
        row_t r;
        bit ok;
        load_w({N{8'h10}});
        for (int k = 0; k < 4; k++) begin
            r = rand_row();
            r[7:0]  = 8'hF8;
            r[15:8] = 8'hFF;
            q.push_back(r);
        end
        queue_batch(q);
        start_batch();
        drive_rows(q, 0, ok);
        wait_upd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL signed_upd_timeout got 0 want 1"); end
        checks++; if (w_out[7:0] !== 8'h14)  begin errors++; $display("FAIL signed_lane0 got %h want 14", w_out[7:0]); end
        checks++; if (w_out[15:8] !== 8'h11) begin errors++; $display("FAIL floor_lane1 got %h want 11", w_out[15:8]); end
    endtask

    task automatic test_saturation();
        row_t q[$];
        bit ok;
        load_w({N{8'h80}});
        repeat (4) q.push_back({N{8'h7F}});
        queue_batch(q);
        start_batch(); drive_rows(q, 0, ok); wait_upd(ok);
        checks++; if (w_out !== {N{8'h80}}) begin errors++; $display("FAIL sat_low got %h want %h", w_out, {N{8'h80}}); end
        q = {};
        load_w({N{8'h7F}});
        repeat (4) q.push_back({N{8'h80}});
        queue_batch(q);
        start_batch(); drive_rows(q, 0, ok); wait_upd(ok);
        checks++; if (w_out !== {N{8'h7F}}) begin errors++; $display("FAIL sat_high got %h want %h", w_out, {N{8'h7F}}); end
    endtask

    task automatic test_backpressure();
        row_t q1[$], q2[$], qa[$];
        int base;
        bit ok;
        load_w(rand_row());
        base = n_hs;
        e_if.err_valid = 1'b1; e_if.err_in = rand_row();
        repeat (3) @(posedge clk); #1;
        e_if.err_valid = 1'b0;
        checks++; if (n_hs != base) begin errors++; $display("FAIL idle_rows_accepted got %0d want 0", n_hs - base); end
        repeat (2) q1.push_back(rand_row());
        repeat (2) q2.push_back(rand_row());
        qa = {q1, q2};
        queue_batch(qa);
        start_batch();
        drive_rows(q1, 40, ok);
        start_batch();
        drive_rows(q2, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_rows_timeout got 0 want 1"); end
        e_if.err_valid = 1'b1; e_if.err_in = rand_row();
        wait_upd(ok);
        e_if.err_valid = 1'b0;
        checks++; if (n_hs - base != 4) begin errors++; $display("FAIL bp_handshakes got %0d want 4", n_hs - base); end
    endtask

    task automatic test_abort();
        row_t q[$];
        row_t w0;
        bit ok;
        bit seen;
        load_w(rand_row());
        w0 = wm;
        repeat (2) q.push_back(rand_row());
        start_batch();
        drive_rows(q, 0, ok);
        abort = 1'b1; e_if.err_valid = 1'b1; e_if.err_in = {N{8'h7F}};
        @(posedge clk); #1;
        abort = 1'b0; e_if.err_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        seen = 1'b0;
        repeat (5) begin @(negedge clk); if (upd_valid) seen = 1'b1; end
        @(posedge clk); #1;
        checks++; if (seen) begin errors++; $display("FAIL abort_upd_valid got 1 want 0"); end
        checks++; if (w_out !== w0) begin errors++; $display("FAIL abort_w_out got %h want %h", w_out, w0); end
        q = {};
        repeat (4) q.push_back({N{8'h10}});
        queue_batch(q);
        start_batch(); drive_rows(q, 0, ok); wait_upd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_next_timeout got 0 want 1"); end
    endtask

    task automatic test_reset_mid();
        row_t q[$];
        bit ok;
        load_w({N{8'h22}});
        repeat (2) q.push_back({N{8'h30}});
        start_batch();
        drive_rows(q, 0, ok);
        resetn = 1'b1; e_if.err_valid = 1'b1; e_if.err_in = {N{8'h30}};
        @(posedge clk); #1;
        checks++; if (w_out !== '0)   begin errors++; $display("FAIL rstmid_w_out got %h want 0", w_out); end
        checks++; if (busy !== 1'b0 || e_if.err_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_state busy=%b err_ready=%b want 0 0", busy, e_if.err_ready);
        end
        resetn = 1'b0; e_if.err_valid = 1'b0;
        wm = '0;
        q = {};
        repeat (4) q.push_back({N{8'h08}});
        queue_batch(q);
        start_batch(); drive_rows(q, 0, ok); wait_upd(ok);
        checks++; if (w_out !== {N{8'hFC}}) begin errors++; $display("FAIL rstmid_next got %h want %h", w_out, {N{8'hFC}}); end
    endtask

    task automatic test_back_to_back();
        row_t q1[$], q2[$];
        bit ok;
        load_w(rand_row());
        repeat (4) q1.push_back(rand_row());
        repeat (4) q2.push_back(rand_row());
        queue_batch(q1);
        queue_batch(q2);
        start_batch(); drive_rows(q1, 0, ok); wait_upd(ok);
        start_batch();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_start got busy=%b want 1", busy); end
        drive_rows(q2, 0, ok); wait_upd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_upd_timeout got 0 want 1"); end
    endtask

    initial begin
        e_if.err_valid = 1'b0;
        e_if.err_in    = '0;
        test_reset();
        test_basic();
        test_signed();
        test_saturation();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mbgd_grad_update.md
MBGD_GRAD_UPDATE -- requirements
Module: mbgd_grad_update

Interface
REQ-001 SHALL have parameter N, default 8: number of lanes per error/weight row.
REQ-002 SHALL have parameter DW, default 8: bits per lane, signed two's complement.
REQ-003 SHALL have parameter BATCH_BITS, default 2: mini-batch size = 2^BATCH_BITS rows.
REQ-004 SHALL have parameter LR_SHIFT, default 1: learning-rate right shift.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begin a batch.
REQ-008 SHALL have port abort, input, 1 bit: discard the current batch.
REQ-009 SHALL have port err_valid, input, 1 bit: err_in holds a valid error row (h - y).
REQ-010 SHALL have port err_ready, output, 1 bit: block accepts a row.
REQ-011 SHALL have port err_in, input, DW*N bits: lane i at bits [(i+1)*DW-1 : i*DW].
REQ-012 SHALL have port w_load, input, 1 bit: load w_in into the weight register.
REQ-013 SHALL have port w_in, input, DW*N bits: initial weights, same lane packing.
REQ-014 SHALL have port w_out, output, DW*N bits: current weights, registered.
REQ-015 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-016 SHALL have port upd_valid, output, 1 bit: one-cycle pulse; new weights on w_out.

Function
REQ-017 SHALL implement states IDLE, ACCUM, UPDATE and DONE.
REQ-018 In IDLE, start=1 SHALL clear all lane accumulators and the row counter, then go to ACCUM; start is ignored in every other state.
REQ-019 w_load SHALL take effect only in IDLE, writing w_out at the next edge; if start and w_load are both high in IDLE, both SHALL take effect.
REQ-020 err_ready SHALL be 1 only in ACCUM, driven combinationally from state.
REQ-021 A row SHALL be accepted only on an edge where err_valid and err_ready are both 1; err_valid without err_ready SHALL change nothing.
REQ-022 Per lane, an accepted row SHALL add the sign-extended err lane to an accumulator of width DW+BATCH_BITS+1, which cannot overflow.
REQ-023 On acceptance of row 2^BATCH_BITS, the state SHALL go to UPDATE; no further rows SHALL be accepted in that batch.
REQ-024 UPDATE lasts exactly one cycle, per lane:
  - grad = acc arithmetically shifted right by BATCH_BITS+LR_SHIFT (floor toward minus infinity);
  - w_new = w - grad, saturated to [-2^(DW-1), 2^(DW-1)-1];
  - w_out is written at the end of the cycle and the state goes to DONE.
REQ-025 DONE SHALL last one cycle with upd_valid=1, then return to IDLE; upd_valid SHALL be 0 in all other states.
REQ-026 Latency from the edge accepting the last row to upd_valid=1 SHALL be 2 cycles, with w_out already updated.
REQ-027 abort=1 in ACCUM or UPDATE SHALL go to IDLE, clear the accumulators and the row counter, leave w_out unchanged and produce no upd_valid.
REQ-028 abort SHALL take priority over a simultaneous row acceptance; abort in IDLE or DONE SHALL be ignored.
REQ-029 Back-to-back batches SHALL be allowed: start in the IDLE cycle right after DONE begins a new batch.

Reset
REQ-030 resetn=1 at an edge SHALL force the following, overriding all other inputs including mid-batch:
  - state IDLE;
  - accumulators, row counter and w_out all zero;
  - upd_valid=0, busy=0, err_ready=0.

Verification
(defaults N=8, DW=8, BATCH_BITS=2, LR_SHIFT=1; total shift 3)
REQ-031 Basic update: load w=0x10 on all lanes, start, then 4 rows of err=0x08 -> acc=32, grad=4, w_out=0x0C on all lanes, upd_valid high exactly 2 cycles after the 4th acceptance.
REQ-032 Signed and floor behaviour:
  - w=0x10, lane0 err=0xF8 x4 -> lane0 w=0x14;
  - lane1 err=0xFF x4 -> acc=-4, grad=-1, lane1 w=0x11.
REQ-033 Saturation:
  - w=0x80, err=0x7F x4 -> grad=63, result 0x80 (clamped);
  - w=0x7F, err=0x80 x4 -> grad=-64, result 0x7F.
REQ-034 Backpressure and ignored inputs: random err_valid gaps -> exactly 4 handshakes counted; rows offered in IDLE or DONE are not accepted; start during ACCUM has no effect.
REQ-035 Abort and reset mid-batch:
  - abort after 2 rows -> busy=0, w_out unchanged, no upd_valid; the next batch accumulates from 0;
  - resetn=1 during ACCUM -> w_out=0 and IDLE at the next edge.
